csa_resolve_adder: RTL and testbench
====================================

Name: csa_resolve_adder

Overview:
- Downstream stage of the 16-bit 4:2 carry-save compressor array.
- Consumes its 17-bit carry-save pair (out_0, out_1) and resolves it to a binary sum through a 2-stage pipelined carry-propagate adder.
- The carry is split at bit SPLIT and registered between the stages to shorten the critical path.
- Valid/ready handshake on both sides; sustains one result per cycle.

Parameters:
- WIDTH, 17, width of each carry-save input operand.
- SPLIT, 9, width of the low segment added in stage 1 (1 <= SPLIT < WIDTH).

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  carry-save pair on in_0/in_1 is valid.
- in_ready  output  1  stage 1 can accept this cycle.
- in_0  input  WIDTH  carry-save operand 0 (compressor out_0).
- in_1  input  WIDTH  carry-save operand 1 (compressor out_1).
- out_valid  output  1  out_sum holds a resolved result.
- out_ready  input  1  consumer accepts out_sum this cycle.
- out_sum  output  WIDTH+1  in_0 + in_1, full width, no truncation.
- busy  output  1  s1_valid | s2_valid.

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release):
  - s1_valid = 0, s2_valid = 0, every data register = 0.
  - Outputs: out_valid = 0, out_sum = 0, busy = 0, in_ready = 1 from the first cycle after release.
- Stage 1 (registers s1_*), loads on accept = in_valid & in_ready:
  - s1_lo = low SPLIT bits of (in_0[SPLIT-1:0] + in_1[SPLIT-1:0]).
  - s1_c = carry-out of that addition.
  - s1_hi0 / s1_hi1 = in_0[WIDTH-1:SPLIT] / in_1[WIDTH-1:SPLIT].
  - s1_valid <= 1.
- Stage 2 (registers s2_*), loads on adv2 = s1_valid & (!s2_valid | out_ready):
  - s2_sum = {s1_hi0 + s1_hi1 + s1_c (WIDTH-SPLIT+1 bits), s1_lo}.
  - s2_valid <= 1.
- Drive out_sum = s2_sum and out_valid = s2_valid.
- Handshake:
  - in_ready = !s1_valid | adv2, combinational from out_ready; no combinational in_valid -> in_ready path.
  - s1_valid next = accept ? 1 : (adv2 ? 0 : s1_valid).
  - s2_valid next = adv2 ? 1 : ((out_valid & out_ready) ? 0 : s2_valid).
  - out_valid, once asserted, stays high with out_sum stable until out_ready; data registers hold whenever their stage does not load.
- Latency: a value accepted in cycle N is on out_sum with out_valid in cycle N+2 if the pipeline is not stalled.
- Throughput: 1 per cycle with out_ready held high.
- Full condition: s1_valid & s2_valid & !out_ready gives in_ready = 0; no data lost and no duplicate issued.
- Simultaneous events, with the pipeline full and out_ready = 1: the output pops, s2 reloads from s1, and s1 reloads from the input, all in the same cycle.
- Empty pipeline: in_valid has no effect on outputs other than through the stage-1 load.
- Arithmetic:
  - Unsigned, modulo 2^(WIDTH+1); the top bit is the final carry.
  - With compressor inputs (in_0 MSB = 0) the result equals the true 4-operand sum.
- Reset mid-operation: in-flight entries are discarded; no out_valid pulse after release until new data is accepted.

Test Plan:
- Reset then single accept in_0=0x001FF, in_1=0x00001 -> out_valid two cycles later with out_sum=0x00200 (carry across SPLIT), busy high for exactly 2 cycles.
- in_0=0x1FFFF, in_1=0x1FFFF -> out_sum=0x3FFFE; in_0=0x0FFFF, in_1=0x00001 -> out_sum=0x10000.
- 8 back-to-back accepts (values 1..8 paired with 0x100) with out_ready=1 -> 8 consecutive out_valid cycles, sums 0x101..0x108 in order, in_ready never drops.
- Fill pipeline, hold out_ready=0 for 5 cycles -> in_ready=0 after 2 accepts, out_sum stable at the first result; release -> both results in order, then in_ready=1.
- Pipeline full with out_ready=1 and in_valid=1 in the same cycle -> pop, shift and accept all happen; a random 1000-transaction stream with random backpressure matches a reference model with no drops.
- Assert reset with both stages valid -> out_valid=0, out_sum=0, busy=0 immediately (asynchronous); after release no stale result appears.

Source files
------------

// File: rtl/csa_resolve_adder.sv
// rtl/csa_resolve_adder.sv - two-stage pipelined carry-propagate adder resolving a carry-save pair
//
// Purpose: accepts the carry-save pair of the 4:2 compressor array and produces
// the full-width binary sum. The low SPLIT bits are added in stage 1 and their
// carry is registered; stage 2 adds the high segments plus that carry.
//
// Ports:
//   clock      in   sole clock, rising edge
//   reset      in   asynchronous active-low reset
//   in_valid   in   carry-save pair on in_0/in_1 is valid
//   in_ready   out  stage 1 can accept this cycle
//   in_0       in   [WIDTH-1:0] carry-save operand 0
//   in_1       in   [WIDTH-1:0] carry-save operand 1
//   out_valid  out  out_sum holds a resolved result
//   out_ready  in   consumer accepts out_sum this cycle
//   out_sum    out  [WIDTH:0] in_0 + in_1, full width
//   busy       out  any stage holds an entry
module csa_resolve_adder #(
  parameter int WIDTH = 17,
  parameter int SPLIT = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             busy
);

  localparam int HW = WIDTH - SPLIT;

  logic             r_s1_valid;
  logic [SPLIT-1:0] r_s1_lo;
  logic             r_s1_c;
  logic [HW-1:0]    r_s1_hi0;
  logic [HW-1:0]    r_s1_hi1;

  logic             r_s2_valid;
  logic [WIDTH:0]   r_s2_sum;

  logic [SPLIT:0]   w_lo_sum;
  logic [HW:0]      w_hi_sum;
  logic             w_adv2;
  logic             w_accept;
  logic             w_pop;

  // Zero-extend by one bit so the segment carry-out lands in the MSB.
  assign w_lo_sum = {1'b0, in_0[SPLIT-1:0]} + {1'b0, in_1[SPLIT-1:0]};
  assign w_hi_sum = {1'b0, r_s1_hi0} + {1'b0, r_s1_hi1} + {{HW{1'b0}}, r_s1_c};

  // Stage 2 can take stage 1's entry when it is empty or draining this cycle.
  assign w_adv2   = r_s1_valid & (~r_s2_valid | out_ready);
  // Depends only on state and out_ready, never on in_valid.
  assign in_ready = ~r_s1_valid | w_adv2;
  assign w_accept = in_valid & in_ready;
  assign w_pop    = r_s2_valid & out_ready;

  assign out_valid = r_s2_valid;
  assign out_sum   = r_s2_sum;
  assign busy      = r_s1_valid | r_s2_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_lo    <= '0;
      r_s1_c     <= 1'b0;
      r_s1_hi0   <= '0;
      r_s1_hi1   <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_lo    <= w_lo_sum[SPLIT-1:0];
        r_s1_c     <= w_lo_sum[SPLIT];
        r_s1_hi0   <= in_0[WIDTH-1:SPLIT];
        r_s1_hi1   <= in_1[WIDTH-1:SPLIT];
      end else if (w_adv2) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
    end else begin
      if (w_adv2) begin
        r_s2_valid <= 1'b1;
        r_s2_sum   <= {w_hi_sum, r_s1_lo};
      end else if (w_pop) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csa_resolve_adder.sv
// tb/tb_csa_resolve_adder.sv - directed and random checks for csa_resolve_adder
module tb_csa_resolve_adder;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] in_0;
  logic [16:0] in_1;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_sum;
  logic        busy;

  int n_assert;
  int n_fail;

  csa_resolve_adder #(.WIDTH(17), .SPLIT(9)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_0     (in_0),
    .in_1     (in_1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [16:0] a, input logic [16:0] b, input logic rdy);
    in_valid  = v;
    in_0      = a;
    in_1      = b;
    out_ready = rdy;
    #1;
  endtask

  initial begin
    logic [17:0] q[$];
    logic [17:0] exp_sum;
    logic [16:0] ra;
    logic [16:0] rb;
    logic        rv;
    logic        rr;
    int          cnt;
    int          acc;
    int          pop;

    n_assert  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_0      = '0;
    in_1      = '0;
    out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_sum", {14'b0, out_sum}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    #2 reset = 1'b1;
    tick();
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Single accept, carry across the split
    drive(1'b1, 17'h001FF, 17'h00001, 1'b1);
    tick();
    drive(1'b0, 17'h0, 17'h0, 1'b1);
    check("single_busy_c1", {31'b0, busy}, 32'd1);
    check("single_ov_c1", {31'b0, out_valid}, 32'd0);
    tick();
    check("single_busy_c2", {31'b0, busy}, 32'd1);
    check("single_ov_c2", {31'b0, out_valid}, 32'd1);
    check("single_sum", {14'b0, out_sum}, 32'h00200);
    tick();
    check("single_busy_c3", {31'b0, busy}, 32'd0);
    check("single_ov_c3", {31'b0, out_valid}, 32'd0);

    // Full-width boundary values, back to back
    drive(1'b1, 17'h1FFFF, 17'h1FFFF, 1'b1);
    tick();
    drive(1'b1, 17'h0FFFF, 17'h00001, 1'b1);
    tick();
    drive(1'b0, 17'h0, 17'h0, 1'b1);
    check("max_ov", {31'b0, out_valid}, 32'd1);
    check("max_sum", {14'b0, out_sum}, 32'h3FFFE);
    tick();
    check("carry16_ov", {31'b0, out_valid}, 32'd1);
    check("carry16_sum", {14'b0, out_sum}, 32'h10000);
    tick();
    check("carry16_drain", {31'b0, out_valid}, 32'd0);

    // Eight back-to-back accepts at full throughput
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, 17'(i + 1), 17'h00100, 1'b1);
      else       drive(1'b0, 17'h0, 17'h0, 1'b1);
      if (i < 8) check("b2b_in_ready", {31'b0, in_ready}, 32'd1);
      if (i >= 2) begin
        check("b2b_ov", {31'b0, out_valid}, 32'd1);
        check("b2b_sum", {14'b0, out_sum}, 32'(32'h0FF + i));
      end
      tick();
    end
    check("b2b_end_ov", {31'b0, out_valid}, 32'd0);

    // Backpressure: fill, stall five cycles, release
    drive(1'b1, 17'h00AAA, 17'h00555, 1'b0);
    check("bp_rdy_a", {31'b0, in_ready}, 32'd1);
    tick();
    drive(1'b1, 17'h12345, 17'h0ABCD, 1'b0);
    check("bp_rdy_b", {31'b0, in_ready}, 32'd1);
    tick();
    drive(1'b1, 17'h00001, 17'h00002, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_stall_rdy", {31'b0, in_ready}, 32'd0);
      check("bp_stall_ov", {31'b0, out_valid}, 32'd1);
      check("bp_stall_sum", {14'b0, out_sum}, 32'h00FFF);
      tick();
    end
    // Full with out_ready and in_valid together: pop, shift and accept at once
    drive(1'b1, 17'h00001, 17'h00002, 1'b1);
    check("bp_release_rdy", {31'b0, in_ready}, 32'd1);
    check("bp_release_sum", {14'b0, out_sum}, 32'h00FFF);
    tick();
    drive(1'b0, 17'h0, 17'h0, 1'b1);
    check("bp_b_ov", {31'b0, out_valid}, 32'd1);
    check("bp_b_sum", {14'b0, out_sum}, 32'h1CF12);
    tick();
    check("bp_c_ov", {31'b0, out_valid}, 32'd1);
    check("bp_c_sum", {14'b0, out_sum}, 32'h00003);
    tick();
    check("bp_end_ov", {31'b0, out_valid}, 32'd0);
    check("bp_end_rdy", {31'b0, in_ready}, 32'd1);

    // Random stream with random backpressure against a queue model
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 2) != 0);
      ra = 17'($urandom_range(0, 32'h1FFFF));
      rb = 17'($urandom_range(0, 32'h1FFFF));
      drive(rv, ra, rb, rr);
      check("rnd_in_ready", {31'b0, in_ready}, {31'b0, (cnt < 2) || rr});
      acc = (rv && in_ready) ? 1 : 0;
      pop = (out_valid && rr) ? 1 : 0;
      if (pop == 1) begin
        if (q.size() == 0) begin
          check("rnd_spurious", {31'b0, out_valid}, 32'd0);
        end else begin
          exp_sum = q.pop_front();
          check("rnd_sum", {14'b0, out_sum}, {14'b0, exp_sum});
        end
      end
      if (acc == 1) q.push_back({1'b0, ra} + {1'b0, rb});
      cnt = cnt + acc - pop;
      tick();
    end
    drive(1'b0, 17'h0, 17'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("drain_spurious", {31'b0, out_valid}, 32'd0);
        end else begin
          exp_sum = q.pop_front();
          check("drain_sum", {14'b0, out_sum}, {14'b0, exp_sum});
        end
      end
      tick();
    end
    check("drain_left", 32'(q.size()), 32'd0);
    check("drain_busy", {31'b0, busy}, 32'd0);

    // Asynchronous reset with both stages valid
    drive(1'b1, 17'h00010, 17'h00020, 1'b0);
    tick();
    drive(1'b1, 17'h00030, 17'h00040, 1'b0);
    tick();
    drive(1'b0, 17'h0, 17'h0, 1'b0);
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    check("pre_rst_ov", {31'b0, out_valid}, 32'd1);
    reset = 1'b0;
    #1;
    check("arst_ov", {31'b0, out_valid}, 32'd0);
    check("arst_sum", {14'b0, out_sum}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    tick();
    #2 reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_ov", {31'b0, out_valid}, 32'd0);
      check("post_rst_busy", {31'b0, busy}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
